clp_instr_exec: RTL
===================

CLP_INSTR_EXEC -- requirements
Module: clp_instr_exec

Interface
REQ-001 SHALL have parameter INSTR_W, default 100, instruction word width.
REQ-002 SHALL have parameter DIM_W, default 10, width of each loop dimension field.
REQ-003 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port enable  input  1  instruction-present request from the sequencer.
REQ-006 SHALL have port instruction  input  INSTR_W  instruction word, valid while enable=1.
REQ-007 SHALL have port state  output  1  0=idle, 1=busy.
REQ-008 SHALL have port issue_valid  output  1  compute-issue strobe.
REQ-009 SHALL have port issue_ready  input  1  downstream accepts issue.
REQ-010 SHALL have port issue_oc / issue_row / issue_col  output  DIM_W each  current loop indices.
REQ-011 SHALL have port issue_addr  output  16  output address = out_base + linear index.
REQ-012 SHALL have port issue_last  output  1  marks final issue of the instruction.
REQ-013 SHALL have port err  output  1  sticky illegal-opcode flag.

Function
REQ-014 Field map SHALL be: [99:96] opcode, [95:86] out_ch, [85:76] height, [75:66] width, [65:50] out_base, [49:0] reserved (ignored).
REQ-015 Opcodes SHALL be: 0 NOP, 1 CONV, 2 POOL; 3-15 illegal.
REQ-016 FSM states SHALL be IDLE, DECODE, RUN, DONE, REARM.
REQ-017 IDLE: enable=1 sampled at edge N -> instruction latched, state=1 from N+1, next DECODE; enable=0 -> stay.
REQ-018 DECODE (one cycle): illegal opcode -> err=1, DONE; NOP or any dimension zero -> DONE; else zero counters, RUN.
REQ-019 RUN: issue_valid=1 every cycle; indices/addr/last SHALL hold stable while issue_valid=1 and issue_ready=0.
REQ-020 Counter order SHALL be col innermost, then row, then oc; col wraps width-1->0 with row+1; row wraps height-1->0 with oc+1.
REQ-021 issue_addr SHALL equal out_base + (oc*height + row)*width + col, truncated modulo 2^16.
REQ-022 issue_last=1 only at oc=out_ch-1, row=height-1, col=width-1; accepted last issue -> DONE next cycle.
REQ-023 Back-to-back acceptance SHALL yield one issue per cycle (no bubbles).
REQ-024 DONE (one cycle): issue_valid=0; enable=0 -> IDLE with state=0 next cycle; enable=1 -> REARM.
REQ-025 REARM: state=0; stays until enable=0, then IDLE; a held enable SHALL NOT start a second instruction.
REQ-026 enable and instruction changes outside IDLE SHALL be ignored; latched copy governs execution.
REQ-027 state SHALL be 1 in DECODE, RUN, DONE; 0 in IDLE, REARM.
REQ-028 err SHALL stay 1 until reset; subsequent legal instructions execute normally.

Reset
REQ-029 rst_n=0 at an edge SHALL force IDLE, state=0, issue_valid=0, issue_last=0, err=0, all indices/addr=0, latched instruction=0.
REQ-030 Reset mid-RUN SHALL abort with no further issues; the first instruction after reset needs a fresh enable.

Structure
REQ-031 Package clp_pkg SHALL hold field offsets/widths, opcode constants and the FSM state enum.
REQ-032 The nested oc/row/col counter with wrap and last detection SHALL be sub-module clp_loop_cnt; address arithmetic stays in the top.

Verification
REQ-033 CONV out_ch=2,h=2,w=3,base=0x0100, ready=1 -> 12 issues on consecutive cycles, addr 0x0100..0x010B, last on 12th, state 1 for 14 cycles.
REQ-034 Same instruction, ready toggled 1,0,0,1... -> each payload held through stall, total 12 accepted, order unchanged.
REQ-035 opcode=7 -> err=1 in the cycle after DECODE, zero issues, state returns 0; subsequent legal CONV 1x1x1 -> one issue.
REQ-036 enable held high for 40 cycles with CONV 1x1x2 -> exactly 2 issues, state parks 0 in REARM until enable=0.
REQ-037 height=0 or NOP -> no issues, state=1 for exactly 2 cycles (DECODE, DONE).
REQ-038 rst_n=0 after 5th issue of REQ-033 case -> outputs reset next edge, no issues until new enable.

Source files
------------

// File: rtl/clp_pkg.sv
// ---------------------------------------------------------------------------
// clp_pkg -- shared definitions for the CLP instruction executor.
//
// Holds the instruction field map (LSB offsets and widths), the opcode
// encodings, the executor FSM state type and small decode helpers used by
// clp_instr_exec and clp_loop_cnt.
// ---------------------------------------------------------------------------
package clp_pkg;

  // Instruction field map (default 100-bit word; bits [49:0] are reserved)
  localparam int OPC_LSB  = 96;
  localparam int OPC_W    = 4;
  localparam int OC_LSB   = 86;
  localparam int HT_LSB   = 76;
  localparam int WD_LSB   = 66;
  localparam int FIELD_W  = 10;
  localparam int BASE_LSB = 50;
  localparam int BASE_W   = 16;
  localparam int ADDR_W   = 16;

  // Opcode encodings; every other value is illegal
  localparam logic [OPC_W-1:0] OPC_NOP  = 4'd0;
  localparam logic [OPC_W-1:0] OPC_CONV = 4'd1;
  localparam logic [OPC_W-1:0] OPC_POOL = 4'd2;

  // Executor FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_RUN    = 3'd2,
    ST_DONE   = 3'd3,
    ST_REARM  = 3'd4
  } clp_state_e;

  // True for the three defined opcodes
  function automatic logic opc_legal(input logic [OPC_W-1:0] opc);
    logic ok;
    case (opc)
      OPC_NOP:  ok = 1'b1;
      OPC_CONV: ok = 1'b1;
      OPC_POOL: ok = 1'b1;
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Externally visible busy flag for a given FSM state
  function automatic logic state_busy(input clp_state_e s);
    logic busy;
    case (s)
      ST_DECODE: busy = 1'b1;
      ST_RUN:    busy = 1'b1;
      ST_DONE:   busy = 1'b1;
      ST_IDLE:   busy = 1'b0;
      ST_REARM:  busy = 1'b0;
      default:   busy = 1'b0;
    endcase
    return busy;
  endfunction

endpackage

// File: rtl/clp_loop_cnt.sv
// ---------------------------------------------------------------------------
// clp_loop_cnt -- nested oc/row/col loop counter with last-iteration flag.
//
// col is the innermost loop, then row, then oc. The counters and the
// last flag are registered; the last flag is computed from the *next*
// counter values so it lines up with the registered indices.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   load                   zero all counters (start of a new instruction)
//   step                   advance by one iteration (accepted, non-last)
//   clear                  zero counters and drop last (after final issue)
//   out_ch, height, width  loop bounds (all non-zero while stepping)
//   oc, row, col           current indices
//   last                   current indices are the final iteration
// ---------------------------------------------------------------------------
module clp_loop_cnt
  import clp_pkg::*;
#(
  parameter int DIM_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             clear,
  input  logic [DIM_W-1:0] out_ch,
  input  logic [DIM_W-1:0] height,
  input  logic [DIM_W-1:0] width,
  output logic [DIM_W-1:0] oc,
  output logic [DIM_W-1:0] row,
  output logic [DIM_W-1:0] col,
  output logic             last
);

  localparam logic [DIM_W-1:0] DIM_ZERO = {DIM_W{1'b0}};
  localparam logic [DIM_W-1:0] DIM_ONE  = DIM_W'(1);

  logic [DIM_W-1:0] oc_r, row_r, col_r;
  logic [DIM_W-1:0] oc_s, row_s, col_s;
  logic             last_r, last_s;
  logic             col_wrap_s, row_wrap_s;

  assign col_wrap_s = (col_r == (width - DIM_ONE));
  assign row_wrap_s = (row_r == (height - DIM_ONE));

  // Next counter values and last-iteration detection on those values
  always_comb begin
    oc_s  = oc_r;
    row_s = row_r;
    col_s = col_r;
    if (load || clear) begin
      oc_s  = DIM_ZERO;
      row_s = DIM_ZERO;
      col_s = DIM_ZERO;
    end else if (step) begin
      if (col_wrap_s) begin
        col_s = DIM_ZERO;
        if (row_wrap_s) begin
          row_s = DIM_ZERO;
          oc_s  = oc_r + DIM_ONE;
        end else begin
          row_s = row_r + DIM_ONE;
        end
      end else begin
        col_s = col_r + DIM_ONE;
      end
    end else begin
      oc_s  = oc_r;
      row_s = row_r;
      col_s = col_r;
    end
    last_s = !clear
             && (oc_s  == (out_ch - DIM_ONE))
             && (row_s == (height - DIM_ONE))
             && (col_s == (width  - DIM_ONE));
  end

  // Counter and last-flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oc_r   <= DIM_ZERO;
      row_r  <= DIM_ZERO;
      col_r  <= DIM_ZERO;
      last_r <= 1'b0;
    end else begin
      oc_r   <= oc_s;
      row_r  <= row_s;
      col_r  <= col_s;
      last_r <= last_s;
    end
  end

  assign oc   = oc_r;
  assign row  = row_r;
  assign col  = col_r;
  assign last = last_r;

endmodule

// File: rtl/clp_instr_exec.sv
// ---------------------------------------------------------------------------
// clp_instr_exec -- executes one CLP loop instruction per enable request.
//
// An instruction is latched in IDLE, decoded for one cycle, then RUN emits
// one compute issue per oc/row/col iteration with valid/ready handshaking.
// DONE lasts one cycle; if enable is still high the block parks in REARM
// until enable drops so a held request never starts a second instruction.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   enable, instruction     request and instruction word from sequencer
//   state                   0 = idle (IDLE/REARM), 1 = busy
//   issue_valid/ready       compute-issue handshake
//   issue_oc/row/col        current loop indices
//   issue_addr              out_base + linear index, modulo 2^16
//   issue_last              final issue of the instruction
//   err                     sticky illegal-opcode flag
// ---------------------------------------------------------------------------
module clp_instr_exec
  import clp_pkg::*;
#(
  parameter int INSTR_W = 100,
  parameter int DIM_W   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [INSTR_W-1:0] instruction,
  output logic               state,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [DIM_W-1:0]   issue_oc,
  output logic [DIM_W-1:0]   issue_row,
  output logic [DIM_W-1:0]   issue_col,
  output logic [ADDR_W-1:0]  issue_addr,
  output logic               issue_last,
  output logic               err
);

  localparam logic [DIM_W-1:0] DIM_ZERO = {DIM_W{1'b0}};

  clp_state_e          fsm_r, fsm_s;
  logic [INSTR_W-1:0]  instr_r;
  logic                state_r;
  logic                valid_r;
  logic                err_r;
  logic [ADDR_W-1:0]   addr_r;

  logic [OPC_W-1:0]    opc_s;
  logic [DIM_W-1:0]    oc_dim_s, ht_dim_s, wd_dim_s;
  logic [BASE_W-1:0]   base_s;
  logic                illegal_s, empty_s;
  logic                accept_s, finish_s, step_s, load_s;
  logic                last_s;
  logic                unused_reserved_s;

  // Field extraction from the latched copy only
  assign opc_s    = instr_r[OPC_LSB  +: OPC_W];
  assign oc_dim_s = instr_r[OC_LSB   +: DIM_W];
  assign ht_dim_s = instr_r[HT_LSB   +: DIM_W];
  assign wd_dim_s = instr_r[WD_LSB   +: DIM_W];
  assign base_s   = instr_r[BASE_LSB +: BASE_W];

  // Reserved bits are latched but carry no meaning
  assign unused_reserved_s = ^instr_r[BASE_LSB-1:0];

  assign illegal_s = !opc_legal(opc_s);
  assign empty_s   = (opc_s == OPC_NOP) || (oc_dim_s == DIM_ZERO)
                     || (ht_dim_s == DIM_ZERO) || (wd_dim_s == DIM_ZERO);

  // valid_r is only ever high in RUN, so acceptance implies RUN
  assign accept_s = valid_r && issue_ready;
  assign finish_s = accept_s && last_s;
  assign step_s   = accept_s && !last_s;
  assign load_s   = (fsm_r == ST_DECODE) && !illegal_s && !empty_s;

  // FSM next-state logic
  always_comb begin
    fsm_s = fsm_r;
    case (fsm_r)
      ST_IDLE: begin
        if (enable) fsm_s = ST_DECODE;
        else        fsm_s = ST_IDLE;
      end
      ST_DECODE: begin
        if (illegal_s || empty_s) fsm_s = ST_DONE;
        else                      fsm_s = ST_RUN;
      end
      ST_RUN: begin
        if (finish_s) fsm_s = ST_DONE;
        else          fsm_s = ST_RUN;
      end
      ST_DONE: begin
        if (enable) fsm_s = ST_REARM;
        else        fsm_s = ST_IDLE;
      end
      ST_REARM: begin
        if (enable) fsm_s = ST_REARM;
        else        fsm_s = ST_IDLE;
      end
      default: fsm_s = ST_IDLE;
    endcase
  end

  // FSM state register and registered state/valid outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_r   <= ST_IDLE;
      state_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      fsm_r   <= fsm_s;
      state_r <= state_busy(fsm_s);
      valid_r <= (fsm_s == ST_RUN);
    end
  end

  // Instruction latch: captured only when a request is taken in IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_r <= {INSTR_W{1'b0}};
    end else if ((fsm_r == ST_IDLE) && enable) begin
      instr_r <= instruction;
    end else begin
      instr_r <= instr_r;
    end
  end

  // Sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if ((fsm_r == ST_DECODE) && illegal_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  // Output address: col is innermost, so the linear index grows by one per
  // accepted issue and the address can simply count up from out_base
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_r <= {ADDR_W{1'b0}};
    end else if (load_s) begin
      addr_r <= base_s;
    end else if (step_s) begin
      addr_r <= addr_r + 16'd1;
    end else if (finish_s) begin
      addr_r <= {ADDR_W{1'b0}};
    end else begin
      addr_r <= addr_r;
    end
  end

  clp_loop_cnt #(
    .DIM_W (DIM_W)
  ) u_loop_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load_s),
    .step   (step_s),
    .clear  (finish_s),
    .out_ch (oc_dim_s),
    .height (ht_dim_s),
    .width  (wd_dim_s),
    .oc     (issue_oc),
    .row    (issue_row),
    .col    (issue_col),
    .last   (last_s)
  );

  assign state       = state_r;
  assign issue_valid = valid_r;
  assign issue_addr  = addr_r;
  assign issue_last  = last_s;
  assign err         = err_r;

endmodule
